// File: rtl/sat_add_pkg.sv
// Shared definitions for the saturating-adder scheduler: data width,
// clamp constants and the result-slot state type.
package sat_add_pkg;

  localparam int DW = 16;

  // Clamp values on signed overflow. The negative clamp is 16'h8001, not
  // 16'h8000, so that both clamp values have the same magnitude.
  localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DW-1:0] SAT_NEG = 16'h8001;

  // The result register is either empty or holding one valid result.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_add16_core.sv
// Combinational 16-bit saturating signed adder: a + b + cin.
// cout is the carry into bit 15. ovf flags that the result was clamped.
module sat_add16_core
  import sat_add_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] sum,
  output logic          cout,
  output logic          ovf
);

  logic [DW-1:0] low;   // sum of bits [14:0]; the MSB is the carry into bit 15
  logic [DW:0]   full;  // full 17-bit sum; the MSB is the carry out of bit 15
  logic          c14;
  logic          c15;

  // Form both carries and clamp when they disagree, which means signed overflow.
  // NOTE: every output of an always_comb gets a value on every path, starting
  // with a default, so that no latch is inferred.
  always_comb begin
    low  = {1'b0, a[DW-2:0]} + {1'b0, b[DW-2:0]} + {{(DW-1){1'b0}}, cin};
    full = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    c14  = low[DW-1];
    c15  = full[DW];
    cout = c14;
    ovf  = c14 ^ c15;
    sum  = full[DW-1:0];
    if (ovf) begin
      // On overflow both operands have the same sign, so b[15] gives the
      // direction of the overflow.
      sum = b[DW-1] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/sat_add_sched.sv
// Shares one saturating signed adder among NREQ requesters.
// Arbitration is round-robin, and the single result register uses a
// valid/ready handshake. At full throughput it completes one op per cycle.
// Optional build macro SAT_ADD_OVF_FLAG_EN adds two outputs: rsp_ovf, a
// registered clamp flag, and ovf_cnt, a saturating count of clamped results.
module sat_add_sched
  import sat_add_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [DW*NREQ-1:0]   req_a,
  input  logic [DW*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_sum,
  output logic                 rsp_cout
`ifdef SAT_ADD_OVF_FLAG_EN
  ,
  output logic                 rsp_ovf,
  output logic [DW-1:0]        ovf_cnt
`endif
);

  // Returns a one-hot grant for the first valid requester, searching from
  // ptr upwards and wrapping at NREQ. It returns zero when nothing is valid.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDW-1:0]  ptr);
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  idx;
    gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if ((gnt == '0) && valid[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [DW-1:0]  sum_q, sum_d;
  logic           cout_q, cout_d;
`ifdef SAT_ADD_OVF_FLAG_EN
  logic           ovf_q, ovf_d;
  logic [DW-1:0]  cnt_q, cnt_d;
`endif

  logic           slot_free;
  logic           xfer;
  logic [IDW-1:0] gnt_id;
  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;
  logic           op_cin;
  logic [DW-1:0]  add_sum;
  logic           add_cout;
  logic           add_ovf;

  // Grant logic. It depends only on the handshake signals, the pointer and the
  // slot state, never on operand values. The selected operands are muxed into
  // the shared adder.
  always_comb begin
    slot_free = (state_q == EMPTY) || rsp_ready;
    req_ready = '0;
    if (rst_n && slot_free) req_ready = rr_pick(req_valid, ptr_q);
    xfer   = |(req_ready & req_valid);
    gnt_id = '0;
    op_a   = '0;
    op_b   = '0;
    op_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        gnt_id = IDW'(i);
        op_a   = req_a[DW*i +: DW];
        op_b   = req_b[DW*i +: DW];
        op_cin = req_cin[i];
      end
    end
  end

  sat_add16_core u_core (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // Next state: load on a transfer, drain when the consumer takes the result
  // without a refill, and hold everything under backpressure.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SAT_ADD_OVF_FLAG_EN
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
`endif
    if (xfer) begin
      state_d = FULL;
      id_d    = gnt_id;
      sum_d   = add_sum;
      cout_d  = add_cout;
      ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef SAT_ADD_OVF_FLAG_EN
      ovf_d   = add_ovf;
      if (add_ovf && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
`endif
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // State register with synchronous active-low reset. A held result is
  // discarded on reset.
  // NOTE: use non-blocking assignments for all clocked state, so that every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SAT_ADD_OVF_FLAG_EN
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SAT_ADD_OVF_FLAG_EN
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
`ifdef SAT_ADD_OVF_FLAG_EN
  assign rsp_ovf   = ovf_q;
  assign ovf_cnt   = cnt_q;
`endif

endmodule

// File: tb/tb_sat_add_sched.sv
// Directed self-checking bench for sat_add_sched (NREQ=4, IDW=2).
// When SAT_ADD_OVF_FLAG_EN is defined it also checks rsp_ovf and ovf_cnt.
module tb_sat_add_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_sum;
  logic                 rsp_cout;
`ifdef SAT_ADD_OVF_FLAG_EN
  logic                 rsp_ovf;
  logic [15:0]          ovf_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  sat_add_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef SAT_ADD_OVF_FLAG_EN
    ,
    .rsp_ovf   (rsp_ovf),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [IDW-1:0] id,
                           input logic [15:0] sum, input logic cout);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    if (v) begin
      check({tag, ".id"},   32'(rsp_id),   32'(id));
      check({tag, ".sum"},  32'(rsp_sum),  32'(sum));
      check({tag, ".cout"}, 32'(rsp_cout), 32'(cout));
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
    req_valid[i]       = v;
    req_a[16*i +: 16]  = a;
    req_b[16*i +: 16]  = b;
    req_cin[i]         = c;
  endtask

  logic [15:0] rr_sum [NREQ];
  int          seq [4];

  initial begin
    rr_sum = '{16'h0010, 16'h0111, 16'h0212, 16'h0313};
    seq    = '{0, 1, 3, 0};
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;

    // Reset: hold it with all requesters valid. req_ready must stay at zero.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'h1111, 16'h2222, 1'b0);
    settle;
    check("rst.ready", 32'(req_ready), 32'h0);
    tick;
    tick;
    check("rst.valid", 32'(rsp_valid), 32'h0);
    check("rst.id",    32'(rsp_id),    32'h0);
    check("rst.sum",   32'(rsp_sum),   32'h0);
    check("rst.cout",  32'(rsp_cout),  32'h0);
`ifdef SAT_ADD_OVF_FLAG_EN
    check("rst.ovf",   32'(rsp_ovf),   32'h0);
    check("rst.cnt",   32'(ovf_cnt),   32'h0);
`endif

    // Single op: req0 computes 5 + 3.
    rst_n     = 1'b1;
    req_valid = '0;
    set_req(0, 1'b1, 16'h0005, 16'h0003, 1'b0);
    settle;
    check("single.ready", 32'(req_ready), 32'h1);
    tick;
    check_rsp("single", 1'b1, 2'd0, 16'h0008, 1'b0);
    req_valid = '0;
    settle;
    check("idle.ready", 32'(req_ready), 32'h0);
    tick;
    check("drain.valid", 32'(rsp_valid), 32'h0);

    // Positive saturation on req1; ptr is now 1.
    set_req(1, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    settle;
    check("pos.ready", 32'(req_ready), 32'h2);
    tick;
    check_rsp("pos", 1'b1, 2'd1, 16'h7FFF, 1'b1);
`ifdef SAT_ADD_OVF_FLAG_EN
    check("pos.ovf", 32'(rsp_ovf), 32'h1);
    check("pos.cnt", 32'(ovf_cnt), 32'h1);
`endif

    // Negative saturation on req2. The slot is FULL but rsp_ready=1, so it is free.
    req_valid = '0;
    set_req(2, 1'b1, 16'h8000, 16'hFFFF, 1'b0);
    settle;
    check("neg.ready", 32'(req_ready), 32'h4);
    tick;
    check_rsp("neg", 1'b1, 2'd2, 16'h8001, 1'b0);
`ifdef SAT_ADD_OVF_FLAG_EN
    check("neg.cnt", 32'(ovf_cnt), 32'h2);
`endif

    // Carry into bit 15 without overflow, with cin=1: 4000+C000+1 = 0001, cout=1.
    req_valid = '0;
    set_req(3, 1'b1, 16'h4000, 16'hC000, 1'b1);
    settle;
    check("cin.ready", 32'(req_ready), 32'h8);
    tick;
    check_rsp("cin", 1'b1, 2'd3, 16'h0001, 1'b1);
`ifdef SAT_ADD_OVF_FLAG_EN
    check("cin.ovf", 32'(rsp_ovf), 32'h0);
    check("cin.cnt", 32'(ovf_cnt), 32'h2);
`endif

    // Round-robin with all four requesters valid; ptr has wrapped to 0.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(i * 16'h0101), 16'h0010, 1'b0);
    for (int k = 0; k < NREQ; k++) begin
      settle;
      check("rr.ready", 32'(req_ready), 32'(1 << k));
      tick;
      check_rsp("rr", 1'b1, IDW'(k), rr_sum[k], 1'b0);
    end

    // Drop req2: the grant order is 0,1,3,0.
    req_valid[2] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      settle;
      check("rr2.ready", 32'(req_ready), 32'(1 << seq[j]));
      tick;
      check_rsp("rr2", 1'b1, IDW'(seq[j]), rr_sum[seq[j]], 1'b0);
    end

    // Backpressure: the slot holds req0's result while req1 waits.
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    settle;
    check("bp.ready", 32'(req_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      check_rsp("bp.hold", 1'b1, 2'd0, 16'h0010, 1'b0);
      check("bp.ready_hold", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    settle;
    check("bp.release", 32'(req_ready), 32'h2);
    tick;
    check_rsp("bp.new", 1'b1, 2'd1, 16'h0111, 1'b0);

    // Another negative clamp, on req2 (8000+8000), leaves ptr at 3.
    req_valid = '0;
    set_req(2, 1'b1, 16'h8000, 16'h8000, 1'b0);
    settle;
    check("neg2.ready", 32'(req_ready), 32'h4);
    tick;
    check_rsp("neg2", 1'b1, 2'd2, 16'h8001, 1'b0);
`ifdef SAT_ADD_OVF_FLAG_EN
    check("neg2.cnt", 32'(ovf_cnt), 32'h3);
`endif

    // Reset while FULL discards the result and returns ptr to 0.
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(i * 16'h0101), 16'h0010, 1'b0);
    settle;
    check("rst2.ready", 32'(req_ready), 32'h0);
    tick;
    check("rst2.valid", 32'(rsp_valid), 32'h0);
    check("rst2.sum",   32'(rsp_sum),   32'h0);
`ifdef SAT_ADD_OVF_FLAG_EN
    check("rst2.ovf", 32'(rsp_ovf), 32'h0);
    check("rst2.cnt", 32'(ovf_cnt), 32'h0);
`endif
    rst_n     = 1'b1;
    req_valid = 4'b1010;
    settle;
    check("rst2.first", 32'(req_ready), 32'h2);
    tick;
    check_rsp("rst2.rsp", 1'b1, 2'd1, 16'h0111, 1'b0);

`ifdef SAT_ADD_OVF_FLAG_EN
    // Overflow counter: 3 clamped ops, then 2 normal ops, all on req0.
    req_valid = '0;
    set_req(0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0);
    repeat (3) tick;
    check("cnt3.sum", 32'(rsp_sum), 32'h7FFF);
    check("cnt3.cnt", 32'(ovf_cnt), 32'h3);
    set_req(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
    repeat (2) tick;
    check("cnt3.norm_sum", 32'(rsp_sum), 32'h0002);
    check("cnt3.norm_ovf", 32'(rsp_ovf), 32'h0);
    check("cnt3.norm_cnt", 32'(ovf_cnt), 32'h3);
    // Clamp enough times to reach FFFF, then confirm the counter sticks there.
    set_req(0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0);
    repeat (65532) tick;
    check("cntsat.reach", 32'(ovf_cnt), 32'hFFFF);
    repeat (3) tick;
    check("cntsat.stick", 32'(ovf_cnt), 32'hFFFF);
    check("cntsat.ovf",   32'(rsp_ovf), 32'h1);
`endif

    req_valid = '0;
    tick;
    tick;
    check("end.valid", 32'(rsp_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sat_add_sched.md
Name: sat_add_sched

Overview:
- Shares one 16-bit saturating signed adder among NREQ requesters.
- Round-robin arbitration; valid/ready handshake on every request port and on the single response port.
- Sits between the per-channel filter stages and the shared adder datapath; one result register, one op per cycle at full throughput.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester id, must be >= clog2(NREQ)

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  grant/accept per requester; one-hot or zero.
- req_a  in  16*NREQ  operand a, requester i at bits [16i+15:16i].
- req_b  in  16*NREQ  operand b, same packing.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  requester index of held result.
- rsp_sum  out  16  saturated sum.
- rsp_cout  out  1  carry out of bit 14 (signed-overflow reference carry).

Behaviour:
- Reset: when rst_n=0 at a clk edge, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rr pointer=0. req_ready is 0 while rst_n=0.
- States: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- Slot free = EMPTY, or FULL and rsp_ready=1 in the same cycle.
- When the slot is free, req_ready is one-hot on the first requester with req_valid=1, searching ptr, ptr+1, ... mod NREQ. Otherwise req_ready=0.
- req_ready is combinational from req_valid, ptr, state and rsp_ready. It never depends on operand values.
- Transfer occurs when req_valid[i] and req_ready[i] are both 1. At the next edge:
  - rsp_valid=1, rsp_id=i.
  - rsp_sum and rsp_cout are loaded from the adder.
  - ptr=(i+1) mod NREQ.
  - Latency: request handshake to rsp_valid is 1 cycle.
- No transfer while FULL and rsp_ready=1: the edge sets rsp_valid=0 and ptr is unchanged.
- FULL and rsp_ready=0: all outputs hold and req_ready=0 (backpressure).
- Adder: 17-bit ripple of a+b+cin.
  - c14 = carry into bit 15, c15 = carry out of bit 15; cout=c14.
  - If c14^c15: sum=16'h7FFF when b[15]=0, else 16'h8001. The negative clamp is symmetric at 8001, not 8000.
  - Otherwise sum = raw 16-bit result.
- Requester-side rules:
  - A requester holds valid and operands stable until its ready.
  - Dropping valid before ready is allowed; the slot is simply not granted.
- Reset mid-operation discards any held result. No response is issued for it.
- ptr only advances on a transfer. An idle NREQ-wide zero req_valid leaves ptr unchanged.

Optional Feature:
- Macro SAT_ADD_OVF_FLAG_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), registered with rsp_sum. It is 1 when saturation clamped the result and resets to 0.
  - Adds a 16-bit saturating counter ovf_cnt output that increments on each clamped transfer, sticks at FFFF and resets to 0.
- Undefined: neither port exists and the behaviour above is unchanged.

Decomposition:
- Shared package sat_add_pkg holds:
  - constants SAT_POS=16'h7FFF and SAT_NEG=16'h8001;
  - DW=16;
  - the state typedef {EMPTY, FULL}.
- One sub-module, sat_add16_core: purely combinational a, b, cin -> sum, cout, ovf, implementing the adder rule above. It is instantiated once.
- Round-robin pick is a function inside sat_add_sched, not a module.

Test Plan:
- Single op: req0 a=0005 b=0003 cin=0, rsp_ready=1 -> next cycle rsp_valid=1, id=0, sum=0008, cout=0.
- Positive saturation: a=7FFF b=0001 cin=0 -> sum=7FFF, cout=1, rsp_ovf=1 (with macro). Negative saturation: a=8000 b=FFFF -> sum=8001, cout=0.
- Round-robin: all four valid continuously, rsp_ready=1 -> grants and rsp_id sequence 0,1,2,3,0,..., one result per cycle. Drop req2 -> sequence 0,1,3,0.
- Backpressure: rsp_ready=0 for 3 cycles with req1 pending -> rsp_* stable and req_ready=0. Raising rsp_ready -> req1 granted same cycle and the new result appears on the next edge.
- Reset: rst_n=0 for one edge while FULL -> rsp_valid=0, ptr=0. The first grant afterwards goes to the lowest valid index.
- Overflow counter (macro defined): 3 clamped ops and 2 normal ops -> ovf_cnt=3. Preload to FFFF via repeated clamps -> stays FFFF.
